// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sequencing masked {j,k} ops from NREQ requesters
// onto a shared JK flip-flop bank and returning the captured q by id.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [NBITS*NREQ-1:0]  req_mask,
  output logic [NBITS-1:0]       jk_j,
  output logic [NBITS-1:0]       jk_k,
  input  logic [NBITS-1:0]       jk_q,
  output logic                   rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [NBITS-1:0]       rsp_q,
  output logic                   busy
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CAPTURE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ID_W-1:0]  r_rr_last;
  logic [ID_W-1:0]  r_id;
  logic [NBITS-1:0] r_jk_j;
  logic [NBITS-1:0] r_jk_k;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [NBITS-1:0] r_rsp_q;

  logic             w_found;
  logic [ID_W-1:0]  w_win;
  logic             w_hs;
  logic [1:0]       w_op;
  logic [NBITS-1:0] w_mask;
  logic [NREQ-1:0]  w_ready;

  // Search starts just past the last winner and wraps.
  always_comb begin : arb
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_rr_last) + k) % NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end
    end
  end

  assign w_hs   = w_found && (r_state == IDLE);
  assign w_op   = req_op[2*w_win +: 2];
  assign w_mask = req_mask[NBITS*w_win +: NBITS];

  always_comb begin
    w_ready = '0;
    if (w_hs) begin
      w_ready[w_win] = 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_hs) w_next = APPLY;
      APPLY:   w_next = CAPTURE;
      CAPTURE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last   <= ID_W'(NREQ - 1);
      r_id        <= '0;
      r_jk_j      <= '0;
      r_jk_k      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_q     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_id      <= w_win;
            r_rr_last <= w_win;
            r_jk_j    <= w_mask & {NBITS{w_op[1]}};
            r_jk_k    <= w_mask & {NBITS{w_op[0]}};
          end
        end
        APPLY: begin
          r_jk_j <= '0;
          r_jk_k <= '0;
        end
        CAPTURE: begin
          r_rsp_q     <= jk_q;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = w_ready;
  assign jk_j      = r_jk_j;
  assign jk_k      = r_jk_k;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_q     = r_rsp_q;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: behavioural JK bank, scoreboard of
// expected responses, vector table plus arbitration/reset sequences.
module tb_jk_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op = '0;
  logic [NBITS*NREQ-1:0] req_mask = '0;
  logic [NBITS-1:0]      jk_j;
  logic [NBITS-1:0]      jk_k;
  logic [NBITS-1:0]      jk_q;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [NBITS-1:0]      rsp_q;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int               id;
    logic [NBITS-1:0] q;
  } rsp_t;

  typedef struct {
    int               id;
    logic [1:0]       op;
    logic [NBITS-1:0] mask;
    logic [NBITS-1:0] exp_q;
  } vec_t;

  rsp_t             sb[$];
  int               grants[$];
  logic [NBITS-1:0] model_q = '0;
  int               model_rr = NREQ - 1;
  vec_t             vecs[6];

  always #5 clk = ~clk;

  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_mask  (req_mask),
    .jk_j      (jk_j),
    .jk_k      (jk_k),
    .jk_q      (jk_q),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .busy      (busy)
  );

  function automatic logic [NBITS-1:0] jk_next(
    input logic [NBITS-1:0] q,
    input logic [NBITS-1:0] j,
    input logic [NBITS-1:0] k
  );
    logic [NBITS-1:0] r;
    for (int b = 0; b < NBITS; b++) begin
      if (j[b] && k[b])  r[b] = ~q[b];
      else if (j[b])     r[b] = 1'b1;
      else if (k[b])     r[b] = 1'b0;
      else               r[b] = q[b];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) jk_q <= '0;
    else        jk_q <= jk_next(jk_q, jk_j, jk_k);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on observed handshake, pop on rsp_valid.
  always @(negedge clk) begin : mon
    rsp_t e;
    int   w;
    logic [NBITS-1:0] m;
    #2;
    if (rst_n) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id %0d q 0x%0h, none expected",
                   rsp_id, rsp_q);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_q", 32'(rsp_q), 32'(e.q));
        end
      end
      if (busy) begin
        chk("ready_busy", 32'(req_ready), 32'd0);
      end else begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          int i;
          i = (model_rr + k) % NREQ;
          if (w < 0 && req_valid[i]) w = i;
        end
        chk("ready_grant", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w >= 0 && req_ready[w]) begin
          m = req_mask[NBITS*w +: NBITS];
          model_q = jk_next(model_q, m & {NBITS{req_op[2*w+1]}},
                            m & {NBITS{req_op[2*w]}});
          sb.push_back('{w, model_q});
          grants.push_back(w);
          model_rr = w;
        end
      end
    end
  end

  task automatic flush_model();
    sb.delete();
    grants.delete();
    model_q  = '0;
    model_rr = NREQ - 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic do_req(input vec_t v);
    int n;
    req_valid[v.id]      = 1'b1;
    req_op[2*v.id +: 2]  = v.op;
    req_mask[NBITS*v.id +: NBITS] = v.mask;
    #1;
    n = 0;
    while (!req_ready[v.id] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      chk("grant_timeout", 32'(n), 32'd0);
      req_valid[v.id] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid[v.id] = 1'b0;
    chk("apply_j", 32'(jk_j), 32'(v.mask & {NBITS{v.op[1]}}));
    chk("apply_k", 32'(jk_k), 32'(v.mask & {NBITS{v.op[0]}}));
    chk("apply_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("capture_j", 32'(jk_j), 32'd0);
    chk("capture_k", 32'(jk_k), 32'd0);
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id_vec", 32'(rsp_id), 32'(v.id));
    chk("rsp_q_vec", 32'(rsp_q), 32'(v.exp_q));
    chk("rsp_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{0, 2'b10, 8'h0F, 8'h0F};
    vecs[1] = '{1, 2'b11, 8'hFF, 8'hF0};
    vecs[2] = '{1, 2'b11, 8'hFF, 8'h0F};
    vecs[3] = '{3, 2'b10, 8'hFF, 8'hFF};
    vecs[4] = '{2, 2'b01, 8'h81, 8'h7E};
    vecs[5] = '{2, 2'b00, 8'hFF, 8'h7E};

    #3 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_jk_j", 32'(jk_j), 32'd0);
    chk("rst_jk_k", 32'(jk_k), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_q", 32'(rsp_q), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_q", 32'(jk_q), 32'd0);

    for (int i = 0; i < 6; i++) do_req(vecs[i]);
    repeat (2) @(negedge clk);
    chk("vec_sb_empty", 32'(sb.size()), 32'd0);

    // All requesters valid for 15 cycles: five grants 0,1,2,3,0.
    do_reset();
    req_op    = 8'hFF;
    req_mask  = 32'h8421_C3A5;
    req_valid = 4'hF;
    repeat (15) @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);
    #1;
    chk("arb_count", 32'(grants.size()), 32'd5);
    if (grants.size() == 5) begin
      chk("arb_g0", 32'(grants[0]), 32'd0);
      chk("arb_g1", 32'(grants[1]), 32'd1);
      chk("arb_g2", 32'(grants[2]), 32'd2);
      chk("arb_g3", 32'(grants[3]), 32'd3);
      chk("arb_g4", 32'(grants[4]), 32'd0);
    end
    chk("arb_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during APPLY: outputs clear asynchronously, no response.
    req_valid[1] = 1'b1;
    req_op[3:2]  = 2'b11;
    req_mask[15:8] = 8'hFF;
    #1;
    n = 0;
    while (!req_ready[1] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("midop_grant_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("midop_apply_j", 32'(jk_j), 32'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_async_j", 32'(jk_j), 32'd0);
    chk("midop_async_k", 32'(jk_k), 32'd0);
    chk("midop_async_busy", 32'(busy), 32'd0);
    flush_model();
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("midop_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    req_valid = 4'b1001;
    req_op    = 8'hFF;
    req_mask  = 32'h0F00_00F0;
    rst_n     = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b0001);
    chk("post_rst_q", 32'(jk_q), 32'd0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!req_ready[3] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("post_rst_wait3", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (5) @(negedge clk);
    #1;
    chk("post_rst_count", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      chk("post_rst_g0", 32'(grants[0]), 32'd0);
      chk("post_rst_g1", 32'(grants[1]), 32'd3);
    end
    chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_q", 32'(jk_q), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
Round-robin command arbiter that shares one bank of NBITS JK_flipflop instances among NREQ requesters. Each requester issues a 2-bit {j,k} op with a per-bit mask. The block sequences one op at a time onto the bank's j/k inputs, captures the resulting q, and returns it tagged with the requester id. It sits between the control requesters and the bank of JK_flipflop instances, which share its clk and rst_n.

Parameters:
NREQ, 4, number of requesters (>=2)
NBITS, 8, number of JK flip-flops in the bank
ID_W, $clog2(NREQ), derived localparam, width of rsp_id

Ports:
clk  input  1  system clock; all state and the bank update on posedge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester grant/accept, one-hot or zero
req_op  input  2*NREQ  per-requester {j,k}; requester i uses bits [2i+1:2i]
req_mask  input  NBITS*NREQ  per-requester bit select; requester i uses bits [NBITS*i +: NBITS]
jk_j  output  NBITS  j inputs to the flip-flop bank
jk_k  output  NBITS  k inputs to the flip-flop bank
jk_q  input  NBITS  q outputs of the flip-flop bank
rsp_valid  output  1  one-cycle response pulse
rsp_id  output  ID_W  requester that owns the response
rsp_q  output  NBITS  bank q after the op
busy  output  1  high when state != IDLE

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low on rst_n.
- Reset values: state=IDLE, jk_j=0, jk_k=0, rsp_valid=0, rsp_id=0, rsp_q=0, rr_last=NREQ-1, latched op/mask/id=0. Reset takes effect immediately, not at the next edge.
- FSM states: IDLE, APPLY, CAPTURE.
- IDLE:
  - Winner = first i with req_valid[i], searching from rr_last+1 mod NREQ upward with wrap.
  - req_ready[winner]=1, combinational from req_valid; all other bits 0.
  - req_ready=0 in every other state.
  - On the edge where req_valid[w] && req_ready[w]: latch op, mask and id=w; set rr_last=w.
  - On the same edge, register jk_j = mask & {NBITS{op[1]}} and jk_k = mask & {NBITS{op[0]}}; go to APPLY.
- APPLY (1 cycle): jk_j/jk_k stable; the bank updates at the closing edge. On that edge, jk_j=0 and jk_k=0 (hold); go to CAPTURE.
- CAPTURE (1 cycle): on the closing edge, rsp_q<=jk_q, rsp_id<=latched id, rsp_valid<=1; go to IDLE.
- rsp_valid is high exactly one cycle, the first IDLE cycle after CAPTURE. rsp_q and rsp_id hold their values until the next response.
- Latency: handshake at edge T, bank updated at T+1, rsp_valid high in cycle T+2..T+3. Max throughput is one op per 3 cycles. A new handshake may occur in the same cycle rsp_valid is high.
- Masked-off bits: j=k=0, so those bits hold.
- Op 00: sequenced normally, bank unchanged, rsp_q returns current q.
- Requester protocol: a requester must hold req_valid until ready. Dropping req_valid before a grant is legal and produces no grant. req_op and req_mask are sampled only at the handshake edge.
- Responses: no backpressure; the consumer must take rsp_valid when it pulses.
- Round-robin fairness: with all requesters valid, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 grants.
- Reset mid-operation: the op is dropped and no rsp_valid is issued. The bank is cleared by the same rst_n. After release, requester 0 has highest priority.

Test Plan:
- Reset: rst_n=0 at t=0, release at t=3 -> all outputs 0, jk_q=0x00; busy=0, req_ready=0 until a request arrives.
- Single set: req 0 valid, op=10, mask=0x0F -> jk_j=0x0F and jk_k=0x00 for exactly one cycle (APPLY); rsp_valid pulses with rsp_id=0, rsp_q=0x0F.
- Toggle: after the set, req 1 sends op=11 mask=0xFF twice -> rsp_q=0xF0, then rsp_q=0x0F. Grants are 3 cycles apart.
- Reset and hold: from q=0xFF, req 2 sends op=01 mask=0x81 -> rsp_q=0x7E. Then op=00 mask=0xFF -> rsp_q=0x7E and jk_j=jk_k=0 throughout.
- Arbitration: all four req_valid held high for 15 cycles -> grant order 0,1,2,3,0; req_ready never multi-hot; rsp_id sequence matches.
- Reset mid-op: assert rst_n=0 during APPLY -> jk_j/jk_k drop to 0 without waiting for an edge; no rsp_valid. After release with req 3 and req 0 valid, req 0 is granted first.
